gaussian_frame_sched: RTL and testbench

GAUSSIAN_FRAME_SCHED -- requirements
Module: gaussian_frame_sched

---
 rtl/gaussian_frame_sched.sv | 174 +++++++++++++++++
 tb/tb_gaussian_frame_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_frame_sched.sv
// Frame-level gate in front of the Gaussian filter: arms on cfg_start, passes whole
// frames only (SOF..EOF), waits for the filter to drain, and flags malformed geometry.
module gaussian_frame_sched #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int DRAIN_MAX  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_img_vsync,
  input  logic        per_img_href,
  input  logic [7:0]  per_img_gray,
  input  logic        cfg_start,
  input  logic        cfg_continuous,
  input  logic        cfg_stop,
  input  logic        cfg_bypass,
  output logic        flt_vsync,
  output logic        flt_href,
  output logic [7:0]  flt_gray,
  output logic        flt_bypass,
  input  logic        flt_post_vsync,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic        err_timeout
);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_SOF, S_ACTIVE, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic          vs_q, hr_q;
  logic [10:0]   h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d, v_next;
  logic [DW-1:0] drain_q, drain_d;
  logic          stop_pend_q, stop_pend_d;
  logic          byp_q, byp_d;
  logic          fvs_q, fhr_q, fvs_d, fhr_d;
  logic [7:0]    fgray_q, fgray_d;
  logic          done_q, done_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          eh_q, ev_q, et_q, eh_d, ev_d, et_d;
  logic          sof, eof, hfall, stop_req, pass;

  assign sof      = !vs_q && per_img_vsync;
  assign eof      = vs_q && !per_img_vsync;
  assign hfall    = hr_q && !per_img_href;
  assign stop_req = cfg_stop || stop_pend_q;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    v_next  = v_cnt_q;
    drain_d = drain_q;
    byp_d   = byp_q;
    fcnt_d  = fcnt_q;
    eh_d    = eh_q;
    ev_d    = ev_q;
    et_d    = et_q;
    done_d  = 1'b0;
    pass    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_ARM;
          eh_d    = 1'b0;
          ev_d    = 1'b0;
          et_d    = 1'b0;
        end
      end
      // Never start mid-frame: wait for vsync low before looking for SOF.
      S_ARM: begin
        if (stop_req)            state_d = S_IDLE;
        else if (!per_img_vsync) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (stop_req) state_d = S_IDLE;
        else if (sof) begin
          state_d = S_ACTIVE;
          byp_d   = cfg_bypass;
          h_cnt_d = per_img_href ? 11'd1 : 11'd0;
          v_cnt_d = '0;
          pass    = 1'b1;
        end
      end
      S_ACTIVE: begin
        pass = 1'b1;
        if (hfall) begin
          if (h_cnt_q != 11'(IMG_H_DISP)) eh_d = 1'b1;
          h_cnt_d = '0;
          if (v_cnt_q != 10'h3FF) v_next = v_cnt_q + 10'd1;
        end else if (per_img_href && h_cnt_q != 11'h7FF) begin
          h_cnt_d = h_cnt_q + 11'd1;
        end
        v_cnt_d = v_next;
        // v_next already includes a line ending on this same cycle.
        if (eof) begin
          if (v_next != 10'(IMG_V_DISP)) ev_d = 1'b1;
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q != '0 && !flt_post_vsync) begin
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 16'd1;
          state_d = (cfg_continuous && !stop_req) ? S_WAIT_SOF : S_IDLE;
        end else if (drain_q + 1'b1 == DW'(DRAIN_MAX)) begin
          et_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    stop_pend_d = (state_d == S_IDLE) ? 1'b0
                : (stop_pend_q || (cfg_stop && state_q != S_IDLE));
    fvs_d   = pass && per_img_vsync;
    fhr_d   = pass && per_img_href;
    fgray_d = pass ? per_img_gray : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      hr_q        <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      drain_q     <= '0;
      stop_pend_q <= 1'b0;
      byp_q       <= 1'b0;
      fvs_q       <= 1'b0;
      fhr_q       <= 1'b0;
      fgray_q     <= '0;
      done_q      <= 1'b0;
      fcnt_q      <= '0;
      eh_q        <= 1'b0;
      ev_q        <= 1'b0;
      et_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= per_img_vsync;
      hr_q        <= per_img_href;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      drain_q     <= drain_d;
      stop_pend_q <= stop_pend_d;
      byp_q       <= byp_d;
      fvs_q       <= fvs_d;
      fhr_q       <= fhr_d;
      fgray_q     <= fgray_d;
      done_q      <= done_d;
      fcnt_q      <= fcnt_d;
      eh_q        <= eh_d;
      ev_q        <= ev_d;
      et_q        <= et_d;
    end
  end

  assign flt_vsync   = fvs_q;
  assign flt_href    = fhr_q;
  assign flt_gray    = fgray_q;
  assign flt_bypass  = byp_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = done_q;
  assign frame_cnt   = fcnt_q;
  assign err_hlen    = eh_q;
  assign err_vlen    = ev_q;
  assign err_timeout = et_q;
endmodule

// File: tb/tb_gaussian_frame_sched.sv
// Directed bench for gaussian_frame_sched with an 8x4 geometry and a 6-cycle filter model.
module tb_gaussian_frame_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        per_img_vsync = 1'b0, per_img_href = 1'b0;
  logic [7:0]  per_img_gray = 8'd0;
  logic        cfg_start = 1'b0, cfg_continuous = 1'b0, cfg_stop = 1'b0, cfg_bypass = 1'b0;
  logic        flt_vsync, flt_href, flt_bypass, flt_post_vsync;
  logic [7:0]  flt_gray;
  logic        busy, frame_done, err_hlen, err_vlen, err_timeout;
  logic [15:0] frame_cnt;
  logic        hold_post = 1'b0;
  logic [5:0]  post_sr = 6'd0;

  int nchk = 0, nerr = 0;
  int pix_cnt = 0, done_cnt = 0, dmis = 0, fid = 0;
  int p0, d0;
  logic        ref_href = 1'b0, ref_vs = 1'b0;
  logic [7:0]  ref_gray = 8'd0;

  gaussian_frame_sched #(.IMG_H_DISP(8), .IMG_V_DISP(4), .DRAIN_MAX(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(per_img_vsync), .per_img_href(per_img_href), .per_img_gray(per_img_gray),
    .cfg_start(cfg_start), .cfg_continuous(cfg_continuous), .cfg_stop(cfg_stop),
    .cfg_bypass(cfg_bypass),
    .flt_vsync(flt_vsync), .flt_href(flt_href), .flt_gray(flt_gray), .flt_bypass(flt_bypass),
    .flt_post_vsync(flt_post_vsync),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_hlen(err_hlen), .err_vlen(err_vlen), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Filter model: vsync comes back 6 cycles later, or held high to force a timeout.
  always @(posedge clk) post_sr <= {post_sr[4:0], flt_vsync};
  assign flt_post_vsync = hold_post | post_sr[5];

  // Reference copy of the source one cycle back, for the pass-through data check.
  always @(posedge clk) begin
    ref_href <= per_img_href;
    ref_gray <= per_img_gray;
    ref_vs   <= per_img_vsync;
  end

  always @(negedge clk) begin
    if (flt_href) begin
      pix_cnt++;
      if (!ref_href || flt_gray !== ref_gray || !flt_vsync) dmis++;
    end
    if (flt_vsync && !ref_vs) dmis++;
    if (frame_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One frame: nl lines of 8 pixels (line short_ln has 7); cfg pulses at chosen lines.
  task automatic frame(input int nl, input int short_ln, input int start_ln,
                       input int stop_ln, input int byp_ln);
    int npx;
    per_img_vsync = 1'b1;
    tick();
    tick();
    for (int l = 0; l < nl; l++) begin
      npx = (l == short_ln) ? 7 : 8;
      for (int p = 0; p < npx; p++) begin
        per_img_href = 1'b1;
        per_img_gray = 8'((fid * 40 + l * 8 + p + 1) & 255);
        cfg_start    = (l == start_ln && p == 0);
        cfg_stop     = (l == stop_ln && p == 0);
        if (l == byp_ln && p == 0) cfg_bypass = ~cfg_bypass;
        tick();
      end
      per_img_href = 1'b0;
      per_img_gray = 8'd0;
      cfg_start    = 1'b0;
      cfg_stop     = 1'b0;
      tick();
      tick();
    end
    per_img_vsync = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    fid++;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_flt_vsync", flt_vsync, 0);
    chk("rst_flt_href", flt_href, 0);
    chk("rst_flt_gray", flt_gray, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_errs", {err_hlen, err_vlen, err_timeout, frame_done, flt_bypass}, 0);
    do_reset();

    // Single frame
    cfg_continuous = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("t1_busy_armed", busy, 1);
    tick();
    p0 = pix_cnt; d0 = done_cnt;
    frame(4, -1, -1, -1, -1);
    chk("t1_pixels", pix_cnt - p0, 32);
    chk("t1_data", dmis, 0);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_busy", busy, 0);
    chk("t1_errs", {err_hlen, err_vlen, err_timeout}, 0);

    // Start mid-frame: that frame is blocked, the next one passes
    do_reset();
    p0 = pix_cnt; d0 = done_cnt;
    frame(4, -1, 1, -1, -1);
    chk("t2_blocked_pixels", pix_cnt - p0, 0);
    chk("t2_blocked_busy", busy, 1);
    frame(4, -1, -1, -1, -1);
    chk("t2_pixels", pix_cnt - p0, 32);
    chk("t2_frame_cnt", frame_cnt, 1);
    chk("t2_busy", busy, 0);

    // Continuous, bypass toggled mid-frame; flt_bypass follows only at SOF
    do_reset();
    cfg_continuous = 1'b1;
    cfg_bypass = 1'b0;
    pulse_start();
    frame(4, -1, -1, -1, 2);
    chk("t3_byp_f1", flt_bypass, 0);
    frame(4, -1, -1, -1, 2);
    chk("t3_byp_f2", flt_bypass, 1);
    frame(4, -1, -1, -1, 2);
    chk("t3_byp_f3", flt_bypass, 0);
    chk("t3_frame_cnt", frame_cnt, 3);
    chk("t3_busy_waiting", busy, 1);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    tick();
    chk("t3_stop_idle", busy, 0);
    chk("t3_no_extra_done", frame_cnt, 3);

    // Continuous with stop during frame 2
    do_reset();
    cfg_bypass = 1'b0;
    pulse_start();
    p0 = pix_cnt;
    frame(4, -1, -1, -1, -1);
    frame(4, -1, -1, 1, -1);
    chk("t4_frame_cnt", frame_cnt, 2);
    chk("t4_busy", busy, 0);
    frame(4, -1, -1, -1, -1);
    chk("t4_pixels", pix_cnt - p0, 64);
    chk("t4_frame_cnt_after", frame_cnt, 2);

    // Malformed frame: 5 lines, one of 7 pixels
    do_reset();
    cfg_continuous = 1'b0;
    pulse_start();
    d0 = done_cnt;
    frame(5, 2, -1, -1, -1);
    chk("t5_err_hlen", err_hlen, 1);
    chk("t5_err_vlen", err_vlen, 1);
    chk("t5_done", done_cnt - d0, 1);
    chk("t5_frame_cnt", frame_cnt, 1);
    pulse_start();
    chk("t5_clear", {err_hlen, err_vlen}, 0);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    tick();
    chk("t5_stop_idle", busy, 0);

    // Drain timeout
    do_reset();
    hold_post = 1'b1;
    pulse_start();
    d0 = done_cnt;
    frame(4, -1, -1, -1, -1);
    for (int i = 0; i < 30; i++) tick();
    chk("t6_err_timeout", err_timeout, 1);
    chk("t6_busy", busy, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
    chk("t6_done", done_cnt - d0, 0);
    hold_post = 1'b0;

    // Reset mid-ACTIVE
    pulse_start();
    per_img_vsync = 1'b1;
    tick();
    tick();
    per_img_href = 1'b1;
    per_img_gray = 8'hA5;
    tick();
    tick();
    chk("t7_pre_href", flt_href, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_href", flt_href, 0);
    chk("t7_vsync_gray", {flt_vsync, flt_gray}, 0);
    chk("t7_busy", busy, 0);
    chk("t7_err_timeout", err_timeout, 0);
    tick();
    rst_n = 1'b1;
    per_img_href = 1'b0;
    per_img_gray = 8'd0;
    per_img_vsync = 1'b0;
    tick();
    p0 = pix_cnt;
    frame(4, -1, -1, -1, -1);
    chk("t7_no_pass", pix_cnt - p0, 0);
    chk("t7_frame_cnt", frame_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
